// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register file.
package spi_regfile_pkg;

    // Frame-level FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA
    } state_t;

    // Value of the leading R/W bit of a frame
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Width of a counter able to hold max(addr_w, data_w)
    function automatic int cnt_width(input int addr_w, input int data_w);
        int m;
        m = (addr_w > data_w) ? addr_w : data_w;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with a history flop and rise/fall detection.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q;
    logic              hist_q;

    // Shift the pin through the synchroniser and keep one cycle of history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RST_VAL}};
            hist_q  <= RST_VAL;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
            hist_q  <= chain_q[STAGES-1];
        end
    end

    assign sync = chain_q[STAGES-1];
    assign rise = sync & ~hist_q;
    assign fall = ~sync & hist_q;

endmodule

// File: rtl/spi_regfile.sv
// SPI mode-0 target owning a bank of control registers; burst read/write
// with address auto-increment, words commit on their last bit.
module spi_regfile
    import spi_regfile_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         ncs,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic [NUM_REGS-1:0]          wr_pulse,
    output logic                         frame_err
);

    localparam int CNT_W = cnt_width(ADDR_W, DATA_W);

    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic ncs_sync, ncs_rise, ncs_fall;
    logic copi_sync, copi_rise_unused, copi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk),
        .sync(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d(ncs),
        .sync(ncs_sync), .rise(ncs_rise), .fall(ncs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d(copi),
        .sync(copi_sync), .rise(copi_rise_unused), .fall(copi_fall_unused)
    );

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 err_d, load_rd, word_wr;
    logic                 sample;
    logic                 rw_q;
    logic [ADDR_W-1:0]    addr_q, addr_shift, addr_plus, rd_addr;
    logic [DATA_W-1:0]    wsr_q, rsr_q, rd_word, wr_word;
    logic                 cipo_q;
    logic [DATA_W-1:0]    regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]  wr_pulse_q;
    logic                 frame_err_q;

    // A chip-select release in the same cycle as an sclk rise discards the bit
    assign sample     = sclk_rise & ~ncs_rise;
    assign addr_shift = {addr_q[ADDR_W-2:0], copi_sync};
    assign addr_plus  = addr_q + ADDR_W'(1);
    assign rd_addr    = (state_q == ST_ADDR) ? addr_shift : addr_plus;
    assign wr_word    = {wsr_q[DATA_W-2:0], copi_sync};

    // Register read mux; out-of-range addresses read as zero
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_addr == ADDR_W'(k)) rd_word = regs_q[k];
        end
    end

    // FSM state and bit counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next-state logic plus per-cycle strobes for the datapath
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        err_d     = 1'b0;
        load_rd   = 1'b0;
        word_wr   = 1'b0;
        if (ncs_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            err_d     = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                        (((state_q == ST_WDATA) || (state_q == ST_RDATA)) &&
                         (bit_cnt_q != '0));
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ncs_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) state_d = ST_ADDR;
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                            state_d   = (rw_q == RW_WRITE) ? ST_WDATA : ST_RDATA;
                            bit_cnt_d = '0;
                            load_rd   = (rw_q == RW_READ);
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_WDATA, ST_RDATA: begin
                    if (sclk_rise) begin
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            bit_cnt_d = '0;
                            word_wr   = (state_q == ST_WDATA);
                            load_rd   = (state_q == ST_RDATA);
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Shift registers, address pointer, register bank and output strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q        <= RW_READ;
            addr_q      <= '0;
            wsr_q       <= '0;
            rsr_q       <= '0;
            cipo_q      <= 1'b0;
            wr_pulse_q  <= '0;
            frame_err_q <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            wr_pulse_q  <= '0;
            frame_err_q <= err_d;
            if (state_q == ST_CMD && sample) rw_q <= copi_sync;
            if (state_q == ST_ADDR && sample) addr_q <= addr_shift;
            if (state_q == ST_WDATA && sample) wsr_q <= wr_word;
            if (word_wr) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (addr_q == ADDR_W'(k)) begin
                        regs_q[k]     <= wr_word;
                        wr_pulse_q[k] <= 1'b1;
                    end
                end
                addr_q <= addr_plus;
            end
            if (load_rd) begin
                rsr_q <= rd_word;
                if (state_q == ST_RDATA) addr_q <= addr_plus;
            end else if (state_q == ST_RDATA && sclk_fall) begin
                cipo_q <= rsr_q[DATA_W-1];
                rsr_q  <= {rsr_q[DATA_W-2:0], 1'b0};
            end
            if (state_q == ST_IDLE) cipo_q <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign regs[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign cipo_oe   = (state_q == ST_RDATA) & ~ncs_sync;
    assign cipo      = cipo_oe & cipo_q;
    assign wr_pulse  = wr_pulse_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regfile.sv
// Self-checking bench for spi_regfile: vector table of frames plus
// hand-written abort and reset sequences; writes scored through a queue.
module tb_spi_regfile;

    localparam int NR   = 5;
    localparam int DW   = 8;
    localparam int AW   = 7;
    localparam int HALF = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sclk = 1'b0;
    logic             copi = 1'b0;
    logic             ncs = 1'b1;
    logic             cipo, cipo_oe, frame_err;
    logic [NR*DW-1:0] regs;
    logic [NR-1:0]    wr_pulse;

    always #5 clk = ~clk;

    spi_regfile #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .cipo(cipo), .cipo_oe(cipo_oe), .regs(regs),
        .wr_pulse(wr_pulse), .frame_err(frame_err)
    );

    int total = 0;
    int bad = 0;
    int err_cnt = 0;

    typedef struct { int a; logic [7:0] d; } wexp_t;
    wexp_t      wq[$];
    logic [7:0] model [NR];

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        int          nw;
        logic [23:0] data;
        logic [23:0] exp_rd;
        int          exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // Scoreboard: each wr_pulse cycle must match the next expected commit
    always @(negedge clk) begin
        wexp_t e;
        if (frame_err === 1'b1) err_cnt++;
        if (wr_pulse !== '0) begin
            if (wq.size() == 0) begin
                chk("wr_pulse_unexpected", 64'(wr_pulse), 64'd0);
            end else begin
                e = wq.pop_front();
                chk("wr_pulse", 64'(wr_pulse), 64'(1) << e.a);
                chk("wr_data", 64'(regs[e.a*DW +: DW]), 64'(e.d));
            end
        end
    end

    task automatic bit_xfer(input logic b, output logic c, output logic oe);
        copi = b;
        repeat (HALF) @(negedge clk);
        c  = cipo;
        oe = cipo_oe;
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic frame(input logic [31:0] f, input int n,
                         output logic [23:0] rd, output int oe_bad);
        logic c, oe, want_oe;
        rd = '0;
        oe_bad = 0;
        ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            bit_xfer(f[31-i], c, oe);
            want_oe = (i >= 1 + AW) && (f[31] == 1'b0);
            if (oe !== want_oe) oe_bad++;
            if (i >= 1 + AW) rd = {rd[22:0], c};
        end
        repeat (HALF) @(negedge clk);
        ncs = 1'b1;
        copi = 1'b0;
        repeat (2*HALF) @(negedge clk);
        if (cipo_oe !== 1'b0 || cipo !== 1'b0) oe_bad++;
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < NR; k++)
            chk($sformatf("%s_r%0d", tag, k), 64'(regs[k*DW +: DW]), 64'(model[k]));
    endtask

    task automatic push_write(input logic [6:0] addr, input int nw, input logic [23:0] data);
        int a;
        logic [7:0] d;
        a = int'(addr);
        for (int w = 0; w < nw; w++) begin
            d = data[23-8*w -: 8];
            if (a < NR) begin
                wq.push_back('{a, d});
                model[a] = d;
            end
            a = (a + 1) % 128;
        end
    endtask

    initial begin
        vec_t        tbl [9];
        logic [23:0] rd;
        int          oe_bad, e0;
        logic        c, oe;

        tbl[0] = '{1'b1, 7'h02, 1, 24'hA50000, 24'h000000, 0};
        tbl[1] = '{1'b1, 7'h03, 3, 24'h112233, 24'h000000, 0};
        tbl[2] = '{1'b1, 7'h01, 1, 24'h3C0000, 24'h000000, 0};
        tbl[3] = '{1'b0, 7'h01, 2, 24'h000000, 24'h003CA5, 0};
        tbl[4] = '{1'b0, 7'h10, 1, 24'h000000, 24'h000000, 0};
        tbl[5] = '{1'b1, 7'h10, 1, 24'hFF0000, 24'h000000, 0};
        tbl[6] = '{1'b0, 7'h03, 3, 24'h000000, 24'h112200, 0};
        tbl[7] = '{1'b1, 7'h7F, 2, 24'hFF9900, 24'h000000, 0};
        tbl[8] = '{1'b0, 7'h7F, 2, 24'h000000, 24'h000099, 0};

        for (int k = 0; k < NR; k++) model[k] = 8'h00;

        repeat (4) @(negedge clk);
        chk("rst_wr_pulse", 64'(wr_pulse), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk("rst_cipo", 64'(cipo), 64'd0);
        chk("rst_cipo_oe", 64'(cipo_oe), 64'd0);
        check_regs("rst");
        rst_n = 1'b1;
        repeat (2*HALF) @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            if (tbl[v].rw) push_write(tbl[v].addr, tbl[v].nw, tbl[v].data);
            e0 = err_cnt;
            frame({tbl[v].rw, tbl[v].addr, tbl[v].data}, 8 + 8*tbl[v].nw, rd, oe_bad);
            chk($sformatf("v%0d_rd", v), 64'(rd), 64'(tbl[v].exp_rd));
            chk($sformatf("v%0d_oe", v), 64'(oe_bad), 64'd0);
            chk($sformatf("v%0d_err", v), 64'(err_cnt - e0), 64'(tbl[v].exp_err));
            chk($sformatf("v%0d_pending", v), 64'(wq.size()), 64'd0);
            check_regs($sformatf("v%0d", v));
        end

        // Abort after 4 data bits of a write to addr 0
        e0 = err_cnt;
        frame({1'b1, 7'h00, 24'hF00000}, 12, rd, oe_bad);
        chk("abort_data_err", 64'(err_cnt - e0), 64'd1);
        check_regs("abort_data");

        // Abort in the middle of the address field
        e0 = err_cnt;
        frame({1'b1, 7'h04, 24'h000000}, 4, rd, oe_bad);
        chk("abort_addr_err", 64'(err_cnt - e0), 64'd1);
        check_regs("abort_addr");

        // Full frame after aborts still commits
        push_write(7'h00, 1, 24'h5A0000);
        e0 = err_cnt;
        frame({1'b1, 7'h00, 24'h5A0000}, 16, rd, oe_bad);
        chk("after_abort_err", 64'(err_cnt - e0), 64'd0);
        chk("after_abort_pending", 64'(wq.size()), 64'd0);
        check_regs("after_abort");

        // Reset mid-address with chip select held low
        ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        bit_xfer(1'b1, c, oe);
        bit_xfer(1'b0, c, oe);
        bit_xfer(1'b0, c, oe);
        bit_xfer(1'b1, c, oe);
        rst_n = 1'b0;
        for (int k = 0; k < NR; k++) model[k] = 8'h00;
        wq.delete();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (HALF) @(negedge clk);
        chk("mid_rst_wr_pulse", 64'(wr_pulse), 64'd0);
        chk("mid_rst_frame_err", 64'(frame_err), 64'd0);
        chk("mid_rst_cipo", 64'(cipo), 64'd0);
        chk("mid_rst_cipo_oe", 64'(cipo_oe), 64'd0);
        check_regs("mid_rst");

        // Clocks while ncs is still low from before reset must be ignored
        e0 = err_cnt;
        for (int i = 0; i < 16; i++) begin
            bit_xfer(i == 0 || (i >= 8 && i != 8 && i != 12), c, oe);
        end
        repeat (HALF) @(negedge clk);
        ncs = 1'b1;
        copi = 1'b0;
        repeat (2*HALF) @(negedge clk);
        chk("ignored_err", 64'(err_cnt - e0), 64'd0);
        check_regs("ignored");

        // Fresh frame after ncs high then low
        push_write(7'h04, 1, 24'h770000);
        e0 = err_cnt;
        frame({1'b1, 7'h04, 24'h770000}, 16, rd, oe_bad);
        chk("post_rst_err", 64'(err_cnt - e0), 64'd0);
        chk("post_rst_pending", 64'(wq.size()), 64'd0);
        check_regs("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
